prod_accum: RTL and testbench



---
 rtl/prod_accum.sv | 75 +++++++
 tb/tb_prod_accum.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prod_accum.sv
// Frame accumulator for 4-bit multiplier products: sums N accepted products,
// then holds the total (with a sticky overflow flag) until the consumer takes it.
module prod_accum #(
    parameter int N  = 4,
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_z,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sum,
    output logic          out_ovf,
    output logic [7:0]    cnt
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(N - 1);

    state_t        state;
    logic [SW-1:0] acc;
    logic          ovf;
    logic [SW:0]   sum_next;

    // One extra bit captures the carry out of the SW-bit running sum.
    assign sum_next = {1'b0, acc} + (SW + 1)'(in_z);

    // Handshake flags decode from state alone, so in_ready never sees out_ready.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);

    // NOTE: every register here updates with <= so all reads see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACC;
            acc     <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid) begin
                        if (cnt == LAST_CNT) begin
                            out_sum <= sum_next[SW-1:0];
                            out_ovf <= ovf | sum_next[SW];
                            acc     <= '0;
                            ovf     <= 1'b0;
                            cnt     <= '0;
                            state   <= HOLD;
                        end else begin
                            acc <= sum_next[SW-1:0];
                            ovf <= ovf | sum_next[SW];
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    // in_z is ignored here; the source keeps it until the next accept.
                    if (out_ready) begin
                        state <= ACC;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: default build (N=4, SW=8), an N=2/SW=4
// build for wrap-around, and an N=1 build for single-product frames.
module tb_prod_accum;

    typedef struct {
        logic [7:0] sum;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // default instance
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_z = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_sum;
    logic       out_ovf;
    logic [7:0] cnt;

    // overflow instance
    logic       o_in_valid = 1'b0;
    logic       o_in_ready;
    logic [3:0] o_in_z = '0;
    logic       o_out_valid;
    logic       o_out_ready = 1'b0;
    logic [3:0] o_out_sum;
    logic       o_out_ovf;
    logic [7:0] o_cnt;

    // single-product instance
    logic       s_in_valid = 1'b0;
    logic       s_in_ready;
    logic [3:0] s_in_z = '0;
    logic       s_out_valid;
    logic       s_out_ready = 1'b0;
    logic [7:0] s_out_sum;
    logic       s_out_ovf;
    logic [7:0] s_cnt;

    int checks   = 0;
    int failures = 0;

    exp_t     exp_q[$];
    int       prod_q[$];
    int       model_cnt;
    bit       model_hold;

    prod_accum #(.N(4), .SW(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .cnt(cnt)
    );

    prod_accum #(.N(2), .SW(4)) dut_ovf (
        .clk(clk), .rst(rst),
        .in_valid(o_in_valid), .in_ready(o_in_ready), .in_z(o_in_z),
        .out_valid(o_out_valid), .out_ready(o_out_ready),
        .out_sum(o_out_sum), .out_ovf(o_out_ovf), .cnt(o_cnt)
    );

    prod_accum #(.N(1), .SW(8)) dut_one (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_z(s_in_z),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_out_sum), .out_ovf(s_out_ovf), .cnt(s_cnt)
    );

    always #5 clk = ~clk;

    // Push the expected result of one frame of products.
    task automatic push_frame(input int vals[$], input int sw);
        int   total = 0;
        exp_t e;
        foreach (vals[i]) total += vals[i];
        e.sum = 8'(total % (1 << sw));
        e.ovf = (total > (1 << sw) - 1);
        exp_q.push_back(e);
    endtask

    // Streams prod_q into the default instance with out_ready=1 and checks
    // every cycle against a small state/count model.
    task automatic drive_stream(input bit gapped, input int exp_cycles);
        int   cyc   = 0;
        bit   phase = 1'b1;
        bit   accept;
        exp_t e;
        out_ready = 1'b1;
        while ((prod_q.size() > 0 || model_hold) && cyc < 200) begin
            in_valid = (prod_q.size() > 0) && (!gapped || phase);
            in_z     = (prod_q.size() > 0) ? 4'(prod_q[0]) : 4'd0;
            checks++;
            if (in_ready !== !model_hold) begin
                failures++;
                $display("FAIL stream_in_ready cyc=%0d: got %b expected %b", cyc, in_ready, !model_hold);
            end
            accept = in_valid && !model_hold;
            @(posedge clk); #1;
            cyc++;
            phase = !phase;
            if (model_hold) begin
                model_hold = 1'b0;
            end else if (accept) begin
                void'(prod_q.pop_front());
                if (model_cnt == 3) begin
                    model_cnt  = 0;
                    model_hold = 1'b1;
                end else begin
                    model_cnt++;
                end
            end
            checks++;
            if (cnt !== 8'(model_cnt)) begin
                failures++;
                $display("FAIL stream_cnt cyc=%0d: got %0d expected %0d", cyc, cnt, model_cnt);
            end
            checks++;
            if (out_valid !== model_hold) begin
                failures++;
                $display("FAIL stream_out_valid cyc=%0d: got %b expected %b", cyc, out_valid, model_hold);
            end
            if (model_hold) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stream_scoreboard: frame with no expectation, got sum %0d", out_sum);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (out_sum !== e.sum || out_ovf !== e.ovf) begin
                        failures++;
                        $display("FAIL stream_frame: got sum %0d ovf %b expected sum %0d ovf %b",
                                 out_sum, out_ovf, e.sum, e.ovf);
                    end
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (cyc != exp_cycles || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stream_cycles: got %0d cycles (%0d frames left) expected %0d cycles",
                     cyc, exp_q.size(), exp_cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'd0 || out_ovf !== 1'b0 || cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: got rdy %b vld %b sum %0d ovf %b cnt %0d expected 1 0 0 0 0",
                     in_ready, out_valid, out_sum, out_ovf, cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        model_cnt  = 0;
        model_hold = 1'b0;
    endtask

    task automatic test_basic_frame();
        int   vals[$] = '{1, 4, 6, 9};
        exp_t e;
        push_frame(vals, 8);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_z     = 4'(vals[i]);
            checks++;
            if (cnt !== 8'(i) || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL basic_cnt[%0d]: got cnt %0d vld %b expected cnt %0d vld 0", i, cnt, out_valid, i);
            end
            @(posedge clk); #1;
        end
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || cnt !== 8'd0) begin
            failures++;
            $display("FAIL basic_hold_entry: got vld %b rdy %b cnt %0d expected 1 0 0", out_valid, in_ready, cnt);
        end
        checks++;
        if (out_sum !== e.sum || out_ovf !== e.ovf) begin
            failures++;
            $display("FAIL basic_sum: got %0d ovf %b expected %0d ovf %b", out_sum, out_ovf, e.sum, e.ovf);
        end
        // in_z changing while held must not disturb the presented total
        in_z = 4'd15;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_sum !== e.sum || cnt !== 8'd0) begin
                failures++;
                $display("FAIL basic_held[%0d]: got vld %b sum %0d cnt %0d expected 1 %0d 0",
                         i, out_valid, out_sum, cnt, e.sum);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_release: got vld %b rdy %b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 4; a++) begin
            int frame[$];
            for (int b = 0; b < 4; b++) begin
                frame.push_back(a * b);
                prod_q.push_back(a * b);
            end
            push_frame(frame, 8);
        end
        // 16 accepts plus one HOLD cycle per frame
        drive_stream(1'b0, 20);
    endtask

    task automatic test_gapped();
        int frame[$] = '{2, 2, 2, 2};
        foreach (frame[i]) prod_q.push_back(frame[i]);
        push_frame(frame, 8);
        drive_stream(1'b1, 8);
    endtask

    task automatic test_reset_mid_frame();
        int frame[$] = '{1, 1, 1, 1};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_z      = 4'd3;
        @(posedge clk); #1;
        in_z = 4'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (cnt !== 8'd2) begin
            failures++;
            $display("FAIL midrst_pre_cnt: got %0d expected 2", cnt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cnt !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_async: got cnt %0d vld %b rdy %b expected 0 0 1", cnt, out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        model_cnt  = 0;
        model_hold = 1'b0;
        foreach (frame[i]) prod_q.push_back(frame[i]);
        push_frame(frame, 8);
        drive_stream(1'b0, 5);
    endtask

    task automatic test_overflow();
        int   f0[$] = '{15, 15};
        int   f1[$] = '{1, 1};
        exp_t e;
        push_frame(f0, 4);
        push_frame(f1, 4);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 2; i++) begin
                o_in_valid = 1'b1;
                o_in_z     = (f == 0) ? 4'(f0[i]) : 4'(f1[i]);
                @(posedge clk); #1;
            end
            o_in_valid = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (o_out_valid !== 1'b1 || o_out_sum !== e.sum[3:0] || o_out_ovf !== e.ovf) begin
                failures++;
                $display("FAIL ovf_frame%0d: got vld %b sum %0d ovf %b expected 1 %0d %b",
                         f, o_out_valid, o_out_sum, o_out_ovf, e.sum[3:0], e.ovf);
            end
            o_out_ready = 1'b1;
            @(posedge clk); #1;
            o_out_ready = 1'b0;
            checks++;
            if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
                failures++;
                $display("FAIL ovf_release%0d: got vld %b rdy %b expected 0 1", f, o_out_valid, o_in_ready);
            end
        end
    endtask

    task automatic test_single();
        int   f[$] = '{7};
        exp_t e;
        push_frame(f, 8);
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        s_in_z      = 4'd7;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0 || s_out_sum !== e.sum || s_out_ovf !== e.ovf) begin
            failures++;
            $display("FAIL single_frame: got vld %b rdy %b sum %0d ovf %b expected 1 0 %0d %b",
                     s_out_valid, s_in_ready, s_out_sum, s_out_ovf, e.sum, e.ovf);
        end
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || s_cnt !== 8'd0) begin
            failures++;
            $display("FAIL single_release: got vld %b rdy %b cnt %0d expected 0 1 0", s_out_valid, s_in_ready, s_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_sweep();
        test_gapped();
        test_reset_mid_frame();
        test_overflow();
        test_single();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
